// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR/Cause/EPC/PRId, mfc0/mtc0/eret, IntReq generation.
// Optional BadVAddr register (reg 8) and BadAddr_M port are enabled by defining CP0_BADVADDR_EN.
module cp0_ctrl #(
  parameter logic [31:0] PRID_VAL   = 32'h20201215,
  parameter logic [31:0] HANDLER_PC = 32'h00004180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        we,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] BadAddr_M,
`endif
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;

  logic [5:0]  im_reg;
  logic        exl_reg;
  logic        ie_reg;
  logic        bd_reg;
  logic [5:0]  ip_reg;
  logic [4:0]  exc_code_reg;
  logic [31:2] epc_reg;

  logic        int_req;
  logic        exc_req;
  logic        sr_wr;
  logic        epc_wr;
  logic [31:0] epc_target;

  // Any pending request is masked while already inside a handler (EXL=1).
  assign int_req = (|(HWInt & im_reg)) & ie_reg & ~exl_reg;
  assign exc_req = (ExcCode_M != 5'd0) & ~exl_reg;
  assign IntReq  = int_req | exc_req;

  // mtc0 is dropped in the cycle an exception is taken.
  assign sr_wr  = we & ~IntReq & (A2 == REG_SR);
  assign epc_wr = we & ~IntReq & (A2 == REG_EPC);

  assign epc_target = BD_M ? (PC_M - 32'd4) : PC_M;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exl_reg <= 1'b0;
    end else if (IntReq) begin
      exl_reg <= 1'b1;
    end else if (EXLClr) begin
      exl_reg <= 1'b0;
    end else if (sr_wr) begin
      exl_reg <= DIn[1];
    end
  end

  // IM/IE still take an mtc0 issued alongside eret; only EXL is overridden.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_reg <= 6'd0;
      ie_reg <= 1'b0;
    end else if (sr_wr) begin
      im_reg <= DIn[15:10];
      ie_reg <= DIn[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bd_reg       <= 1'b0;
      exc_code_reg <= 5'd0;
    end else if (IntReq) begin
      bd_reg       <= BD_M;
      exc_code_reg <= int_req ? 5'd0 : ExcCode_M;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc_reg <= 30'd0;
    end else if (IntReq) begin
      epc_reg <= epc_target[31:2];
    end else if (epc_wr) begin
      epc_reg <= DIn[31:2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ip_reg <= 6'd0;
    end else begin
      ip_reg <= HWInt;
    end
  end

`ifdef CP0_BADVADDR_EN
  logic [31:0] badvaddr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      badvaddr_reg <= 32'd0;
    end else if (exc_req && (ExcCode_M == 5'd4 || ExcCode_M == 5'd5)) begin
      badvaddr_reg <= BadAddr_M;
    end
  end
`endif

  // mfc0 read port sees committed state only; no bypass of a same-cycle mtc0.
  always_comb begin
    DOut = 32'd0;
    case (A1)
      REG_SR:    DOut = {16'b0, im_reg, 8'b0, exl_reg, ie_reg};
      REG_CAUSE: DOut = {bd_reg, 15'b0, ip_reg, 3'b0, exc_code_reg, 2'b0};
      REG_EPC:   DOut = {epc_reg, 2'b00};
      REG_PRID:  DOut = PRID_VAL;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: DOut = badvaddr_reg;
`else
      REG_BADVADDR: DOut = 32'd0;
`endif
      default:   DOut = 32'd0;
    endcase
  end

  assign EPC        = {epc_reg, 2'b00};
  assign handler_pc = HANDLER_PC;

  logic unused_bits;
  assign unused_bits = ^{DIn[31:16], DIn[9:2], epc_target[1:0]};

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed testbench for cp0_ctrl: reset, mtc0/mfc0, interrupts, exceptions, eret and BadVAddr.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        we;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] BadAddr_M;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;
  logic [31:0] handler_pc;

  int vectors;
  int miscompares;

  cp0_ctrl dut (
    .clk(clk),
    .reset(reset),
    .A1(A1),
    .A2(A2),
    .DIn(DIn),
    .we(we),
    .PC_M(PC_M),
    .BD_M(BD_M),
    .ExcCode_M(ExcCode_M),
    .HWInt(HWInt),
    .EXLClr(EXLClr),
`ifdef CP0_BADVADDR_EN
    .BadAddr_M(BadAddr_M),
`endif
    .IntReq(IntReq),
    .EPC(EPC),
    .DOut(DOut),
    .handler_pc(handler_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    we = 1'b0; A2 = 5'd0; DIn = 32'd0; EXLClr = 1'b0;
    ExcCode_M = 5'd0; BD_M = 1'b0; HWInt = 6'd0; BadAddr_M = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; A1 = 5'd0; PC_M = 32'd0; idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // load some state so the asynchronous reset has something to clear
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    @(negedge clk);
    A2 = 5'd14; DIn = 32'h0000_1234;
    @(negedge clk);
    we = 1'b0; A1 = 5'd12; HWInt = 6'b000001; #1;
    vectors++;
    if (IntReq !== 1'b1) begin miscompares++; $display("FAIL pre_reset_intreq: got %b want 1", IntReq); end
    #1 reset = 1'b1; #1;
    vectors++;
    if (DOut !== 32'd0) begin miscompares++; $display("FAIL reset_sr: got %h want 00000000", DOut); end
    vectors++;
    if (EPC !== 32'd0) begin miscompares++; $display("FAIL reset_epc: got %h want 00000000", EPC); end
    vectors++;
    if (IntReq !== 1'b0) begin miscompares++; $display("FAIL reset_intreq: got %b want 0", IntReq); end
    @(negedge clk);
    reset = 1'b0; HWInt = 6'd0; A1 = 5'd15; #1;
    vectors++;
    if (DOut !== 32'h2020_1215) begin miscompares++; $display("FAIL prid: got %h want 20201215", DOut); end
    vectors++;
    if (handler_pc !== 32'h0000_4180) begin miscompares++; $display("FAIL handler_pc: got %h want 00004180", handler_pc); end
    A1 = 5'd13; #1;
    vectors++;
    if (DOut !== 32'd0) begin miscompares++; $display("FAIL reset_cause: got %h want 00000000", DOut); end
  endtask

  task automatic test_mtc0_sr();
    @(negedge clk);
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    @(negedge clk);
    we = 1'b0; A1 = 5'd12; PC_M = 32'h0000_2000; #1;
    vectors++;
    if (DOut !== 32'h0000_FC01) begin miscompares++; $display("FAIL sr_write: got %h want 0000fc01", DOut); end
    HWInt = 6'b000100; #1;
    vectors++;
    if (IntReq !== 1'b1) begin miscompares++; $display("FAIL hwint_req: got %b want 1", IntReq); end
    @(posedge clk); #1;
    vectors++;
    if (IntReq !== 1'b0) begin miscompares++; $display("FAIL exl_masks: got %b want 0", IntReq); end
    vectors++;
    if (DOut !== 32'h0000_FC03) begin miscompares++; $display("FAIL sr_exl_set: got %h want 0000fc03", DOut); end
    A1 = 5'd13; #1;
    vectors++;
    if (DOut !== 32'h0000_1000) begin miscompares++; $display("FAIL int_cause: got %h want 00001000", DOut); end
    vectors++;
    if (EPC !== 32'h0000_2000) begin miscompares++; $display("FAIL int_epc: got %h want 00002000", EPC); end
  endtask

  task automatic test_exc_delay_slot();
    @(negedge clk);
    HWInt = 6'd0; we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC00;
    @(negedge clk);
    we = 1'b0; ExcCode_M = 5'd10; BD_M = 1'b1; PC_M = 32'h0000_3010; #1;
    vectors++;
    if (IntReq !== 1'b1) begin miscompares++; $display("FAIL exc_req: got %b want 1", IntReq); end
    @(posedge clk); #1;
    vectors++;
    if (EPC !== 32'h0000_300C) begin miscompares++; $display("FAIL bd_epc: got %h want 0000300c", EPC); end
    A1 = 5'd13; #1;
    vectors++;
    if (DOut !== 32'h8000_0028) begin miscompares++; $display("FAIL bd_cause: got %h want 80000028", DOut); end
  endtask

  task automatic test_priority_masking();
    @(negedge clk);
    ExcCode_M = 5'd0; BD_M = 1'b0; we = 1'b1; A2 = 5'd12; DIn = 32'h0000_FC01;
    @(negedge clk);
    we = 1'b0; HWInt = 6'b000001; ExcCode_M = 5'd4; PC_M = 32'h0000_4000; #1;
    vectors++;
    if (IntReq !== 1'b1) begin miscompares++; $display("FAIL prio_req: got %b want 1", IntReq); end
    @(posedge clk); #1;
    A1 = 5'd13; #1;
    vectors++;
    if (DOut !== 32'h0000_0400) begin miscompares++; $display("FAIL prio_cause: got %h want 00000400", DOut); end
    vectors++;
    if (EPC !== 32'h0000_4000) begin miscompares++; $display("FAIL prio_epc: got %h want 00004000", EPC); end
    @(negedge clk);
    HWInt = 6'd0; ExcCode_M = 5'd4; PC_M = 32'h0000_5000; #1;
    vectors++;
    if (IntReq !== 1'b0) begin miscompares++; $display("FAIL nested_mask: got %b want 0", IntReq); end
    @(posedge clk); #1;
    vectors++;
    if (EPC !== 32'h0000_4000) begin miscompares++; $display("FAIL nested_epc: got %h want 00004000", EPC); end
    vectors++;
    if (DOut !== 32'h0000_0000) begin miscompares++; $display("FAIL nested_cause: got %h want 00000000", DOut); end
  endtask

  task automatic test_eret();
    @(negedge clk);
    ExcCode_M = 5'd0; EXLClr = 1'b1; we = 1'b1; A2 = 5'd14; DIn = 32'h0000_3003;
    @(posedge clk); #1;
    A1 = 5'd12; #1;
    vectors++;
    if (DOut !== 32'h0000_FC01) begin miscompares++; $display("FAIL eret_sr: got %h want 0000fc01", DOut); end
    vectors++;
    if (EPC !== 32'h0000_3000) begin miscompares++; $display("FAIL eret_epc: got %h want 00003000", EPC); end
    @(negedge clk);
    EXLClr = 1'b0; we = 1'b0; ExcCode_M = 5'd10; PC_M = 32'h0000_6000;
    @(negedge clk);
    ExcCode_M = 5'd0; EXLClr = 1'b1; we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0C03; #1;
    vectors++;
    if (DOut !== 32'h0000_FC03) begin miscompares++; $display("FAIL exc_sets_exl: got %h want 0000fc03", DOut); end
    @(posedge clk); #1;
    vectors++;
    if (DOut !== 32'h0000_0C01) begin miscompares++; $display("FAIL eret_beats_mtc0: got %h want 00000c01", DOut); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    EXLClr = 1'b0; we = 1'b1; A2 = 5'd14; DIn = 32'h0000_AAA8;
    ExcCode_M = 5'd12; PC_M = 32'h0000_7000; #1;
    vectors++;
    if (IntReq !== 1'b1) begin miscompares++; $display("FAIL b2b_req: got %b want 1", IntReq); end
    @(posedge clk); #1;
    vectors++;
    if (EPC !== 32'h0000_7000) begin miscompares++; $display("FAIL mtc0_dropped: got %h want 00007000", EPC); end
    A1 = 5'd13; #1;
    vectors++;
    if (DOut !== 32'h0000_0030) begin miscompares++; $display("FAIL b2b_cause: got %h want 00000030", DOut); end
    A1 = 5'd20; #1;
    vectors++;
    if (DOut !== 32'd0) begin miscompares++; $display("FAIL unmapped_read: got %h want 00000000", DOut); end
  endtask

  task automatic test_badvaddr();
    logic [31:0] want;
`ifdef CP0_BADVADDR_EN
    want = 32'h0000_0003;
`else
    want = 32'h0000_0000;
`endif
    @(negedge clk);
    we = 1'b0; ExcCode_M = 5'd0; EXLClr = 1'b1;
    @(negedge clk);
    EXLClr = 1'b0; ExcCode_M = 5'd5; BadAddr_M = 32'h0000_0003; PC_M = 32'h0000_8000;
    @(posedge clk); #1;
    ExcCode_M = 5'd0; A1 = 5'd8; #1;
    vectors++;
    if (DOut !== want) begin miscompares++; $display("FAIL badvaddr: got %h want %h", DOut, want); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mtc0_sr();
    test_exc_delay_slot();
    test_priority_masking();
    test_eret();
    test_back_to_back();
    test_badvaddr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller. It sits beside the M stage and is the source of the IntReq flush that the W-stage pipeline register consumes.
- Holds SR, Cause, EPC and PRId, and services mfc0/mtc0/eret.
- Arbitrates hardware interrupts against synchronous exceptions reported by the M stage.
- Produces IntReq, which flushes the pipeline registers and redirects fetch to the handler.

Parameters:
- PRID_VAL, 32'h20201215, read-only value returned for PRId (reg 15).
- HANDLER_PC, 32'h00004180, exception vector reported on handler_pc.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- A1  in  5  mfc0 read register number
- A2  in  5  mtc0 write register number
- DIn  in  32  mtc0 write data
- we  in  1  mtc0 write enable (M stage)
- PC_M  in  32  PC of the instruction in M
- BD_M  in  1  M instruction is in a branch delay slot
- ExcCode_M  in  5  pending synchronous exception code, 0 = none
- HWInt  in  6  hardware interrupt lines [7:2]
- EXLClr  in  1  eret in M
- IntReq  out  1  take exception/interrupt this cycle
- EPC  out  32  current EPC register
- DOut  out  32  mfc0 read data
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Register map:
  - SR(12) = {16'b0, IM[15:10], 8'b0, EXL[1], IE[0]}.
  - Cause(13) = {BD[31], 15'b0, IP[15:10], 3'b0, ExcCode[6:2], 2'b0}.
  - EPC(14) = 32 bits, bits [1:0] forced to 0.
  - PRId(15) = PRID_VAL.
  - Any other A1 reads 0.
- DOut is combinational from A1 and reflects the current register state. There is no same-cycle bypass of a concurrent mtc0.
- Interrupt and exception detection (combinational):
  - int_req = |(HWInt & IM) & IE & ~EXL.
  - exc_req = (ExcCode_M != 0) & ~EXL.
  - IntReq = int_req | exc_req.
  - Interrupt has priority over exception.
- On posedge clk with IntReq=1:
  - EXL <= 1.
  - BD <= BD_M.
  - EPC <= BD_M ? PC_M-4 : PC_M, with bits [1:0] cleared.
  - ExcCode <= int_req ? 0 : ExcCode_M.
  - mtc0 and EXLClr in the same cycle are ignored.
- Else if EXLClr=1: EXL <= 0. A simultaneous mtc0 still applies, except that an mtc0 write of EXL loses to EXLClr.
- Else if we=1:
  - A2=12 writes IM and EXL, IE from DIn.
  - A2=14 writes EPC from DIn with bits [1:0] cleared.
  - Writes to 13 and 15 are ignored.
- IP <= HWInt every cycle, unconditionally, including during IntReq.
- Reset (async, immediate):
  - IM=0, EXL=0, IE=0.
  - BD=0, IP=0, ExcCode=0.
  - EPC=0.
  - IntReq therefore goes to 0 immediately, since IM=0 and ExcCode_M is gated by EXL only, and ExcCode_M is 0 while upstream registers are in reset.
- Nested events: while EXL=1 all requests are masked, and EPC and Cause hold their values.
- Latency: IntReq is visible in the same cycle as the request; register updates land at the next posedge.

Optional Feature:
- Macro: CP0_BADVADDR_EN.
- With the macro defined:
  - Adds input BadAddr_M[31:0] and register BadVAddr(8), reset to 0.
  - Loaded from BadAddr_M on posedge with exc_req=1 and ExcCode_M equal to 4 (AdEL) or 5 (AdES).
  - Readable via A1=8; mtc0 to 8 is ignored.
- Without the macro: no BadAddr_M port, and A1=8 reads 0.

Test Plan:
- Reset and readout: assert reset mid-cycle → all outputs drop asynchronously. Then:
  - A1=15 → DOut=32'h20201215.
  - A1=12 → DOut=0.
  - IntReq=0.
- mtc0 SR: we=1, A2=12, DIn=32'h0000_FC01 → next cycle A1=12 reads 32'h0000_FC01. Then set HWInt=6'b000100 → IntReq=1 the same cycle. After posedge:
  - EXL=1 and IntReq=0.
  - Cause=32'h0000_1000.
  - EPC=PC_M.
- Exception in delay slot: ExcCode_M=10, BD_M=1, PC_M=32'h0000_3010, IE=0 → IntReq=1. After posedge:
  - EPC=32'h0000_300C.
  - Cause=32'h8000_0028.
- Priority and masking: HWInt enabled together with ExcCode_M=4 → ExcCode captured as 0. With EXL=1 and ExcCode_M=4 → IntReq=0 and EPC unchanged.
- eret: EXLClr=1 while EXL=1 → next cycle SR.EXL=0. A same-cycle mtc0 to A2=14 with DIn=32'h3003 → EPC=32'h3000. A same-cycle mtc0 to A2=12 setting EXL → EXL still 0.
- CP0_BADVADDR_EN defined: ExcCode_M=5, BadAddr_M=32'h0000_0003 → A1=8 reads 32'h0000_0003. With the macro undefined → A1=8 reads 0.
